// File: rtl/uart_host_ctrl_if.sv
// uart_host_ctrl_if: signal bundle between uart_host_ctrl and its neighbours.
// It carries the upstream TX byte stream, the downstream RX byte stream, and
// the UART register bus (cs/nrw/addr/datin/datout) plus the UART interrupt.
//
// Handshake rule for both byte streams: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. The producer holds
// its data and valid stable from the cycle valid rises until that transfer
// cycle, and it never withdraws valid before the transfer. The consumer
// may raise or lower ready at any time.
interface uart_host_ctrl_if;
    // upstream byte stream (to be transmitted)
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    // downstream byte stream (received)
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    // UART register bus
    logic       cs;
    logic       nrw;
    logic [2:0] addr;
    logic [7:0] datin;
    logic [7:0] datout;
    logic       uart_int;

    // controller side
    modport master (
        input  tx_data, tx_valid, rx_ready, datout, uart_int,
        output tx_ready, rx_data, rx_valid, cs, nrw, addr, datin
    );

    // environment side: byte producers/consumers and the UART itself
    modport slave (
        output tx_data, tx_valid, rx_ready, datout, uart_int,
        input  tx_ready, rx_data, rx_valid, cs, nrw, addr, datin
    );
endinterface

// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: synthesizable bus initiator for the UART register block.
// After reset it writes CTRL_INIT to the control register, then polls the
// status register. A set rx_full (with no byte waiting downstream) leads to
// an RX-data read that is offered on rx_data/rx_valid; a set tx_empty with a
// pending upstream byte leads to a TX-data write that accepts the byte.
//
// Build option: define UART_HOST_IRQ_EN to replace the periodic status poll
// with polling on the UART interrupt (uart_int). Without it, uart_int is
// ignored and the status register is polled every POLL_INTERVAL idle cycles.
//
// The FSM state is visible on dbg_state (encoding of state_t below).
module uart_host_ctrl #(
    parameter logic [7:0] CTRL_INIT     = 8'h03,
    parameter int         POLL_INTERVAL = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_host_ctrl_if.master bus,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_STAT = 3'd1;
    localparam logic [2:0] ADDR_CTRL = 3'd2;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_STAT_RD  = 3'd2,
        S_STAT_CAP = 3'd3,
        S_RX_RD    = 3'd4,
        S_RX_CAP   = 3'd5,
        S_TX_WR    = 3'd6
    } state_t;

    state_t     state;
    state_t     state_nx;

    // Last known tx_empty; lets a waiting byte trigger a poll straight away.
    logic       tx_empty_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;

    // Combinational bus drive, gated to zero while reset is high.
    logic       cs_c;
    logic       nrw_c;
    logic [2:0] addr_c;
    logic [7:0] datin_c;
    logic       tx_ready_c;

    // Status fields as seen on datout during the capture cycle.
    logic       stat_rx_full;
    logic       stat_tx_empty;
    logic       poll_due;

    assign stat_rx_full  = bus.datout[0];
    assign stat_tx_empty = bus.datout[1];

`ifdef UART_HOST_IRQ_EN
    // Interrupt-driven: the UART tells us when the status is worth reading.
    assign poll_due = bus.uart_int;
`else
    localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

    logic [15:0] poll_cnt;
    logic        unused_irq;

    assign unused_irq = bus.uart_int;
    assign poll_due   = (poll_cnt == POLL_LAST);

    // Idle-cycle counter: restarts on every status capture, saturates at the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= 16'd0;
        end else if (state == S_STAT_CAP) begin
            poll_cnt <= 16'd0;
        end else if (state == S_IDLE && poll_cnt != POLL_LAST) begin
            poll_cnt <= poll_cnt + 16'd1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; RX service takes priority over TX at each status capture.
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT: begin
                state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (poll_due || (bus.tx_valid && tx_empty_q)) begin
                    state_nx = S_STAT_RD;
                end
            end
            S_STAT_RD: begin
                state_nx = S_STAT_CAP;
            end
            S_STAT_CAP: begin
                if (stat_rx_full && !rx_valid_q) begin
                    state_nx = S_RX_RD;
                end else if (stat_tx_empty && bus.tx_valid) begin
                    state_nx = S_TX_WR;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RX_RD: begin
                state_nx = S_RX_CAP;
            end
            S_RX_CAP: begin
                state_nx = S_IDLE;
            end
            S_TX_WR: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_INIT;
            end
        endcase
    end

    // Bus strobe decode: one cs cycle per access state, everything zero otherwise.
    always_comb begin
        cs_c       = 1'b0;
        nrw_c      = 1'b0;
        addr_c     = 3'd0;
        datin_c    = 8'd0;
        tx_ready_c = 1'b0;
        if (!rst) begin
            case (state)
                S_INIT: begin
                    cs_c    = 1'b1;
                    nrw_c   = 1'b1;
                    addr_c  = ADDR_CTRL;
                    datin_c = CTRL_INIT;
                end
                S_STAT_RD: begin
                    cs_c   = 1'b1;
                    addr_c = ADDR_STAT;
                end
                S_RX_RD: begin
                    cs_c   = 1'b1;
                    addr_c = ADDR_DATA;
                end
                S_TX_WR: begin
                    cs_c       = 1'b1;
                    nrw_c      = 1'b1;
                    addr_c     = ADDR_DATA;
                    datin_c    = bus.tx_data;
                    tx_ready_c = 1'b1;
                end
                default: begin
                    cs_c = 1'b0;
                end
            endcase
        end
    end

    // tx_empty cache: refreshed at status capture, cleared once we hand a byte to the UART.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_empty_q <= 1'b1;
        end else if (state == S_STAT_CAP) begin
            tx_empty_q <= stat_tx_empty;
        end else if (state == S_TX_WR) begin
            tx_empty_q <= 1'b0;
        end
    end

    // Downstream RX holding register: loaded from the RX read, released on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else if (state == S_RX_CAP) begin
            rx_data_q  <= bus.datout;
            rx_valid_q <= 1'b1;
        end else if (rx_valid_q && bus.rx_ready) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign bus.cs       = cs_c;
    assign bus.nrw      = nrw_c;
    assign bus.addr     = addr_c;
    assign bus.datin    = datin_c;
    assign bus.tx_ready = tx_ready_c;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: directed bench for uart_host_ctrl. A small UART model
// answers status and RX-data reads; every expected non-status bus access and
// every expected RX byte is queued by the stimulus and checked by a monitor.
module tb_uart_host_ctrl;

`ifdef UART_HOST_IRQ_EN
    localparam int FIRST_POLL  = 2;
    localparam int POLL_PERIOD = 3;
    localparam bit IRQ_BUILD   = 1'b1;
`else
    localparam int FIRST_POLL  = 17;
    localparam int POLL_PERIOD = 18;
    localparam bit IRQ_BUILD   = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    uart_host_ctrl_if bus();
    logic [2:0] dbg_state;

    uart_host_ctrl #(
        .CTRL_INIT    (8'h03),
        .POLL_INTERVAL(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];     // {nrw, addr, datin} of expected non-status accesses
    logic [7:0]  exp_rx_q[$];  // expected downstream RX bytes

    logic [7:0] status_val;
    logic [7:0] rx_val;
    int cyc           = 0;
    int stat_reads    = 0;
    int last_stat_cyc = 0;
    int last_init_cyc = 0;
    int last_rx_rd_cyc = 0;
    int last_tx_wr_cyc = 0;
    int tx_ready_cnt  = 0;
    int cs_cnt        = 0;
    logic prev_cs     = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (timeout or unexpected event)", name);
    endtask

    // ---------------- monitor + UART model ----------------
    initial begin
        bus.datout = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_cs = 1'b0;
            end else begin
                if (bus.cs) begin
                    cs_cnt++;
                    if (prev_cs) fail_now("back_to_back_cs");
                    if (!bus.nrw && bus.addr == 3'd1) begin
                        stat_reads++;
                        last_stat_cyc = cyc;
                        bus.datout = status_val;
                    end else if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_access actual=%0h required=none",
                                 {bus.nrw, bus.addr, bus.datin});
                    end else begin
                        check("bus_access", int'({bus.nrw, bus.addr, bus.datin}),
                              int'(exp_q.pop_front()));
                        if (!bus.nrw && bus.addr == 3'd0) begin
                            last_rx_rd_cyc = cyc;
                            bus.datout = rx_val;
                        end
                        if (bus.nrw && bus.addr == 3'd0) last_tx_wr_cyc = cyc;
                        if (bus.nrw && bus.addr == 3'd2) last_init_cyc = cyc;
                    end
                end
                if (bus.tx_ready) begin
                    tx_ready_cnt++;
                    check("tx_ready_with_write", int'({bus.cs, bus.nrw, bus.addr}), int'(5'b11000));
                end
                if (bus.rx_valid && bus.rx_ready) begin
                    if (exp_rx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rx_byte actual=%0h required=none", bus.rx_data);
                    end else begin
                        check("rx_byte", int'(bus.rx_data), int'(exp_rx_q.pop_front()));
                    end
                end
                prev_cs = bus.cs;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_q_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now(name);
            exp_q.delete();
        end
    endtask

    task automatic wait_stat_read(input string name, input int budget);
        int start;
        int n;
        start = stat_reads;
        n = 0;
        while (stat_reads == start && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (stat_reads == start) fail_now(name);
    endtask

    task automatic send_tx(input logic [7:0] d, input int budget, output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        while (!seen && lat < budget) begin
            @(negedge clk);
            #1;
            lat++;
            if (bus.tx_ready) seen = 1'b1;
        end
        if (!seen) fail_now("tx_handshake");
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'd0;
    endtask

    task automatic wait_rx_valid(input int budget, output bit seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            #1;
            n++;
            if (bus.rx_valid) seen = 1'b1;
        end
        if (!seen) fail_now("rx_valid_wait");
    endtask

    task automatic accept_rx();
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int p;
        int c0;
        bit seen;

        rst          = 1'b1;
        bus.tx_data  = 8'd0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        bus.uart_int = IRQ_BUILD;
        status_val   = 8'h00;
        rx_val       = 8'h00;

        // reset state and the control write that follows release
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_outputs", int'({bus.cs, bus.nrw, bus.addr, bus.datin, bus.tx_ready,
                                     bus.rx_valid, bus.rx_data}), 0);
        check("reset_state", int'(dbg_state), 0);
        exp_q.push_back({1'b1, 3'd2, 8'h03});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("first_access_init_write", int'({bus.cs, bus.nrw, bus.addr, bus.datin}),
              int'({1'b1, 1'b1, 3'd2, 8'h03}));
        wait_q_empty("init_write", 5);

        // periodic status polls
        wait_stat_read("poll_1", 60);
        check("first_poll_delay", last_stat_cyc - last_init_cyc, FIRST_POLL);
        wait_stat_read("poll_2", 60);
        p = last_stat_cyc;
        wait_stat_read("poll_3", 60);
        check("poll_interval", last_stat_cyc - p, POLL_PERIOD);

        // TX byte once the UART reports tx_empty
        @(posedge clk);
        #1;
        status_val = 8'h02;
        exp_q.push_back({1'b1, 3'd0, 8'hA5});
        send_tx(8'hA5, 80, lat);
        wait_q_empty("tx_a5", 10);
        check("tx_ready_pulses_1", tx_ready_cnt, 1);

        // TX with tx_empty already cached: write strobe 3 cycles after IDLE leaves
        wait_stat_read("poll_tx_cache", 60);
        bus.uart_int = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back({1'b1, 3'd0, 8'h5A});
        send_tx(8'h5A, 20, lat);
        check("tx_cached_latency", lat, 4);
        bus.uart_int = IRQ_BUILD;
        wait_q_empty("tx_5a", 10);
        check("tx_ready_pulses_2", tx_ready_cnt, 2);

        // RX byte with downstream backpressure
        status_val = 8'h01;
        rx_val     = 8'h3C;
        exp_q.push_back({1'b0, 3'd0, 8'h00});
        exp_rx_q.push_back(8'h3C);
        wait_rx_valid(80, seen);
        if (seen) begin
            check("rx_latency", cyc - last_stat_cyc, 4);
            check("rx_data_3c", int'(bus.rx_data), 8'h3C);
        end
        repeat (60) @(posedge clk);
        #1;
        check("rx_held", int'({bus.rx_valid, bus.rx_data}), int'({1'b1, 8'h3C}));
        check("no_extra_rx_read", exp_q.size(), 0);
        status_val = 8'h00;
        accept_rx();
        @(negedge clk);
        #1;
        check("rx_valid_cleared", int'(bus.rx_valid), 0);
        check("rx_3c_consumed", exp_rx_q.size(), 0);

        // rx_full and tx_empty together: RX read first, TX write on the next poll
        status_val = 8'h03;
        rx_val     = 8'hC3;
        exp_q.push_back({1'b0, 3'd0, 8'h00});
        exp_q.push_back({1'b1, 3'd0, 8'h55});
        exp_rx_q.push_back(8'hC3);
        send_tx(8'h55, 80, lat);
        status_val = 8'h00;
        wait_q_empty("rx_then_tx", 10);
        check("rx_to_tx_spacing", last_tx_wr_cyc - last_rx_rd_cyc, 5);
        check("rx_c3_waiting", int'({bus.rx_valid, bus.rx_data}), int'({1'b1, 8'hC3}));
        accept_rx();
        @(negedge clk);
        #1;
        check("rx_c3_consumed", exp_rx_q.size(), 0);

        // reset in the cycle after a status read strobe
        status_val = 8'h01;
        rx_val     = 8'h99;
        wait_stat_read("poll_before_reset", 60);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("reset_mid_cs_low", int'(bus.cs), 0);
        @(posedge clk);
        #1;
        status_val = 8'h00;
        @(negedge clk);
        #1;
        check("reset_mid_outputs", int'({bus.cs, bus.nrw, bus.addr, bus.datin, bus.tx_ready,
                                         bus.rx_valid, bus.rx_data}), 0);
        check("reset_mid_state", int'(dbg_state), 0);
        exp_q.push_back({1'b1, 3'd2, 8'h03});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("reinit_write", int'({bus.cs, bus.nrw, bus.addr, bus.datin}),
              int'({1'b1, 1'b1, 3'd2, 8'h03}));
        wait_q_empty("reinit", 5);

`ifdef UART_HOST_IRQ_EN
        // interrupt mode: silent bus without uart_int, quick poll when it rises
        repeat (10) @(posedge clk);
        #1;
        bus.uart_int = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        c0 = cs_cnt;
        repeat (100) @(posedge clk);
        #1;
        check("irq_idle_no_strobes", cs_cnt - c0, 0);
        p = stat_reads;
        bus.uart_int = 1'b1;
        lat = 0;
        while (stat_reads == p && lat < 10) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("irq_poll_within_2", int'(lat <= 2 && stat_reads != p), 1);
        bus.uart_int = 1'b0;
`else
        c0 = cs_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("periodic_polls_continue", int'(cs_cnt - c0 >= 2), 1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("queues_drained", exp_q.size() + exp_rx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // overall time bound
    initial begin
        #5000000;
        $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_host_ctrl.md
Name: uart_host_ctrl

Overview:
- CPU-side bus initiator for uart_top; it is the other end of the UART register interface.
- Replaces the behavioural tester's bus driving with synthesizable RTL.
- Converts an upstream byte stream (valid/ready) into TX-data register writes.
- Polls the status register and delivers received bytes downstream (valid/ready), so a datapath can use the UART without a processor.

Parameters:
- CTRL_INIT, 8'h03: value written to the control register (addr 3'd2) once after reset.
- POLL_INTERVAL, 16: idle cycles between status polls when nothing is pending; minimum 1.

Ports:
- clk  in  1  system clock (10 MHz)
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted this cycle
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data valid; held until accepted
- rx_ready  in  1  downstream accepts rx_data
- cs  out  1  UART chip select, one-cycle strobe per access
- nrw  out  1  0 = read, 1 = write
- addr  out  3  UART register address
- datin  out  8  write data to UART
- datout  in  8  read data from UART, valid the cycle after the read strobe
- uart_int  in  1  UART interrupt request, active high

Behaviour:
- Register map targeted:
  - 3'd0: write = TX data, read = RX data
  - 3'd1: status; bit0 = rx_full, bit1 = tx_empty
  - 3'd2: control
- Bus access: exactly one cycle with cs=1; addr/nrw/datin valid in that cycle. cs=0 in every other cycle, with addr/nrw/datin driven 0.
- Read data is sampled from datout in the cycle after the cs=1 read cycle. There are never back-to-back cs cycles.
- Reset (any cycle, including mid-access):
  - cs=0, nrw=0, addr=0, datin=0, tx_ready=0, rx_valid=0, rx_data=0
  - poll counter=0, FSM→INIT
  - Any in-flight access is abandoned.
- FSM states and transitions:
  - INIT: issue write addr=2, datin=CTRL_INIT → IDLE.
  - IDLE: when the poll counter reaches POLL_INTERVAL-1, or (tx_valid && tx_empty_cached) → STAT_RD. Otherwise increment the counter.
  - STAT_RD: cs=1, nrw=0, addr=1 → STAT_CAP.
  - STAT_CAP: capture datout into status cache; clear poll counter.
    - Priority 1: rx_full && !rx_valid → RX_RD.
    - Priority 2: tx_empty && tx_valid → TX_WR.
    - Otherwise → IDLE.
  - RX_RD: cs=1, nrw=0, addr=0 → RX_CAP.
  - RX_CAP: rx_data←datout, rx_valid←1; tx_empty_cached unchanged → IDLE.
  - TX_WR: cs=1, nrw=1, addr=0, datin=tx_data; tx_ready=1 this cycle only; tx_empty_cached←0 → IDLE.
- Latency:
  - From tx_valid with tx_empty cached set: STAT_RD, STAT_CAP, then TX_WR write strobe, 3 cycles after IDLE leaves.
  - RX byte: rx_valid rises 4 cycles after the STAT_RD strobe that sees rx_full.
- tx_ready is asserted only in TX_WR. Upstream must hold tx_data/tx_valid stable until tx_ready.
- rx_valid clears in the cycle after rx_valid && rx_ready.
- No new RX read is issued while rx_valid=1 (backpressure). The UART holds the byte; overruns are the UART's responsibility.
- Simultaneous rx_full and tx_empty with tx_valid: RX serviced first, TX on the next status poll, which is issued immediately from IDLE because tx_valid && tx_empty_cached is re-checked.
- tx_empty_cached resets to 1. It is updated only at STAT_CAP and cleared at TX_WR.
- Poll counter saturates at POLL_INTERVAL-1 and is 16 bits wide.

Optional Feature:
- Macro: UART_HOST_IRQ_EN.
- Defined: IDLE leaves for STAT_RD only on uart_int=1 (sampled) or (tx_valid && tx_empty_cached). The periodic poll counter is removed.
- Not defined: uart_int is ignored (port still present); periodic polling as above.

Test Plan:
- Reset then release: first bus cycle after rst drops is cs=1, nrw=1, addr=2, datin=8'h03. All outputs are 0 during reset.
- tx_valid=1, tx_data=8'hA5, UART status reads 8'h02 → write strobe addr=0, datin=8'hA5, tx_ready pulses 1 cycle, exactly one write.
- Status reads 8'h01, datout at RX read = 8'h3C, rx_ready=0 → rx_valid=1, rx_data=8'h3C held. No further addr=0 reads until rx_ready=1 for one cycle, then rx_valid=0.
- Status reads 8'h03 with tx_valid=1, tx_data=8'h55 → RX read occurs before the TX write. Both complete within 10 cycles.
- rst asserted in the cycle after a STAT_RD strobe → no capture, cs=0 next cycle, INIT control write repeats after release.
- With UART_HOST_IRQ_EN, idle for 100 cycles with uart_int=0 → zero cs strobes. uart_int=1 → status read within 2 cycles.
